// File: rtl/mult_div.sv
// Iterative 32-bit multiply/divide unit driving the HI/LO registers.
// The divide datapath is present only when MULT_DIV_DIVIDE_EN is defined.
module mult_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] op_1,
    input  logic [31:0] op_2,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic        sign_q, sign_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic        accept;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] prod;

`ifdef MULT_DIV_DIVIDE_EN
    logic        div_q, div_d;
    logic        dbz_q, dbz_d;
    logic        sign_r_q, sign_r_d;
    logic [31:0] rem_q, rem_d;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] rem_sub;
`endif

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
        div_d    = div_q;
        dbz_d    = dbz_q;
        sign_r_d = sign_r_q;
        rem_d    = rem_q;
        accept   = start;
`else
        // Divide requests are dropped when the divider is not built.
        accept   = start & ~md_op[1];
`endif

        signed_op = ~md_op[0];
        a_mag     = (signed_op && op_1[31]) ? (~op_1 + 32'd1) : op_1;
        b_mag     = (signed_op && op_2[31]) ? (~op_2 + 32'd1) : op_2;

        // Shift-add: multiplier sits in acc_q[31:0] and shifts out as product bits shift in.
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        prod    = sign_q ? (~acc_q + 64'd1) : acc_q;

`ifdef MULT_DIV_DIVIDE_EN
        // Restoring divide: dividend shifts out of acc_q[31:0], quotient bits shift in.
        div_shift = {rem_q, acc_q[31]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        rem_sub   = div_shift[31:0] - mcand_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCalc;
                    cnt_d   = 5'd0;
                    sign_d  = signed_op & (op_1[31] ^ op_2[31]);
`ifdef MULT_DIV_DIVIDE_EN
                    div_d    = md_op[1];
                    dbz_d    = (op_2 == 32'd0);
                    sign_r_d = signed_op & op_1[31];
                    rem_d    = 32'd0;
                    acc_d    = {32'd0, md_op[1] ? a_mag : b_mag};
                    mcand_d  = md_op[1] ? b_mag : a_mag;
`else
                    acc_d    = {32'd0, b_mag};
                    mcand_d  = a_mag;
`endif
                end else if (!start) begin
                    if (mthi) hi_d = op_1;
                    if (mtlo) lo_d = op_1;
                end
            end
            StCalc: begin
`ifdef MULT_DIV_DIVIDE_EN
                if (div_q) begin
                    rem_d = div_ge ? rem_sub : div_shift[31:0];
                    acc_d = {acc_q[63:32], acc_q[30:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
`else
                acc_d = {mul_sum, acc_q[31:1]};
`endif
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = StFix;
            end
            StFix: begin
`ifdef MULT_DIV_DIVIDE_EN
                if (div_q) begin
                    // Divide by zero leaves |op_1| in rem; re-negating restores raw op_1.
                    lo_d = dbz_q ? 32'hFFFF_FFFF
                                 : (sign_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
                    hi_d = sign_r_q ? (~rem_q + 32'd1) : rem_q;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
`else
                hi_d = prod[63:32];
                lo_d = prod[31:0];
`endif
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            mcand_q  <= 32'd0;
            acc_q    <= 64'd0;
            sign_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
            div_q    <= 1'b0;
            dbz_q    <= 1'b0;
            sign_r_q <= 1'b0;
            rem_q    <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULT_DIV_DIVIDE_EN
            div_q    <= div_d;
            dbz_q    <= dbz_d;
            sign_r_q <= sign_r_d;
            rem_q    <= rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: vector table plus hand-written corner sequences.
module tb_mult_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] op_1;
    logic [31:0] op_2;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[16];
    int   nv;

    mult_div dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .md_op (md_op),
        .op_1  (op_1),
        .op_2  (op_2),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el);
        vecs[nv].op     = op;
        vecs[nv].a      = a;
        vecs[nv].b      = b;
        vecs[nv].exp_hi = eh;
        vecs[nv].exp_lo = el;
        nv++;
    endtask

    // glitch_kind: 0 none, 1 extra start pulse, 2 mthi pulse, at busy cycle glitch_at.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int glitch_kind, input int glitch_at);
        logic [31:0] hi0, lo0;
        int n;
        @(negedge clk);
        hi0   = hi;
        lo0   = lo;
        start = 1'b1;
        md_op = op;
        op_1  = a;
        op_2  = b;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        op_1  = 32'h5A5A_5A5A;
        op_2  = 32'hA5A5_A5A5;
        n = 0;
        while (busy && n < 100) begin
            start = 1'b0;
            mthi  = 1'b0;
            if (n == glitch_at && glitch_kind == 1) begin
                start = 1'b1;
                md_op = 2'b01;
                op_1  = 32'h0000_0003;
                op_2  = 32'h0000_0005;
            end
            if (n == glitch_at && glitch_kind == 2) begin
                mthi = 1'b1;
                op_1 = 32'hDEAD_BEEF;
            end
            if (n == 16) begin
                chk({name, "_hold_hi"}, hi, hi0);
                chk({name, "_hold_lo"}, lo, lo0);
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        mthi  = 1'b0;
        chk({name, "_latency"}, n, 32'd33);
        chk({name, "_done"}, {31'd0, done}, 32'd1);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        @(negedge clk);
        chk({name, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [31:0] v);
        @(negedge clk);
        mthi = h;
        mtlo = l;
        op_1 = v;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
    endtask

    initial begin
        int  seen_done;
        int  seen_busy;
        rst   = 1'b1;
        start = 1'b0;
        md_op = 2'b00;
        op_1  = 32'd0;
        op_2  = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        nv    = 0;

        add_vec(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        add_vec(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        add_vec(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        add_vec(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        add_vec(2'b00, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000);
        add_vec(2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        add_vec(2'b00, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        add_vec(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
`ifdef MULT_DIV_DIVIDE_EN
        add_vec(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        add_vec(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        add_vec(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        add_vec(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        add_vec(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        add_vec(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
`endif

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 0, 0);
        end

        // Extra start mid-operation is ignored.
        run_op("mid_start", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1, 5);

        // MT writes land on the next edge; both at once write both.
        @(negedge clk);
        mthi = 1'b1;
        op_1 = 32'h0000_1234;
        @(negedge clk);
        chk("mthi", hi, 32'h0000_1234);
        mthi = 1'b0;
        mtlo = 1'b1;
        op_1 = 32'h0000_5678;
        @(negedge clk);
        chk("mtlo", lo, 32'h0000_5678);
        chk("mtlo_hi_kept", hi, 32'h0000_1234);
        mtlo = 1'b0;
        mt_write(1'b1, 1'b1, 32'h0000_CAFE);
        chk("mt_both_hi", hi, 32'h0000_CAFE);
        chk("mt_both_lo", lo, 32'h0000_CAFE);

        // MTHI while busy has no effect.
        run_op("mthi_busy", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 2, 5);

        // start together with mthi: the operation wins.
        mt_write(1'b1, 1'b0, 32'h0000_0077);
        mthi = 1'b1;
        run_op("start_mthi", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 0, 0);

        // Reset mid-operation.
        mt_write(1'b1, 1'b0, 32'h0000_00AA);
        mt_write(1'b0, 1'b1, 32'h0000_00BB);
        chk("pre_rst_hi", hi, 32'h0000_00AA);
        @(negedge clk);
        start = 1'b1;
        md_op = 2'b00;
        op_1  = 32'd9;
        op_2  = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("rst_no_done", seen_done, 32'd0);

`ifndef MULT_DIV_DIVIDE_EN
        // Divide requests are dropped without the divider.
        mt_write(1'b1, 1'b1, 32'h0000_0042);
        @(negedge clk);
        start = 1'b1;
        md_op = 2'b10;
        op_1  = 32'd100;
        op_2  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        seen_busy = 0;
        seen_done = 0;
        repeat (40) begin
            if (busy) seen_busy++;
            if (done) seen_done++;
            @(negedge clk);
        end
        chk("nodiv_busy", seen_busy, 32'd0);
        chk("nodiv_done", seen_done, 32'd0);
        chk("nodiv_hi", hi, 32'h0000_0042);
        chk("nodiv_lo", lo, 32'h0000_0042);
`else
        seen_busy = 0;
        chk("div_build_idle", {31'd0, busy}, seen_busy);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
